datapath_exec: RTL and testbench

- Architectural datapath for the 16-bit non-pipelined accumulator CPU. It sits directly downstream of the control unit.
- It holds PC, AR, IR, DR, AC and E, and runs the memory transactions for fetch, indirect-address resolve and operand read/write.
- It performs the ALU/shift operations selected by the control unit's strobes.
- It returns o_ir and a one-cycle o_ex_done, which feed back into the control unit.

---
 rtl/datapath_exec.sv | 264 ++++++++++++++++++++++++++
 tb/tb_datapath_exec.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_exec.sv
`default_nettype none
// =============================================================================
// datapath_exec : register file, ALU and memory sequencer of the accumulator CPU
// Rev 1.0
// =============================================================================
module datapath_exec #(
  parameter int                DWIDTH   = 16,
  parameter int                AWIDTH   = 12,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_fetch,
  input  logic              i_is_ind,
  input  logic              i_is_dir,
  input  logic              i_execute,
  input  logic              i_add,
  input  logic              i_load,
  input  logic              i_store,
  input  logic              i_branch,
  input  logic              i_isz,
  input  logic              i_clr_ac,
  input  logic              i_clr_e,
  input  logic              i_comp_ac,
  input  logic              i_load_ac,
  input  logic              i_cir_r,
  input  logic              i_cir_l,
  input  logic              i_inc_ac,
  input  logic              i_clr_reg,
  output logic [DWIDTH-1:0] o_ir,
  output logic              o_ex_done,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [DWIDTH-1:0] o_mem_wdata,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [DWIDTH-1:0] o_ac,
  output logic              o_e,
  output logic [AWIDTH-1:0] o_pc
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_IND    = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_RD = 3'd4,
    S_MEM_WR = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE    = 4'd0,
    OP_CLR_REG = 4'd1,
    OP_DIR     = 4'd2,
    OP_CLR_AC  = 4'd3,
    OP_CLR_E   = 4'd4,
    OP_COMP_AC = 4'd5,
    OP_LOAD_AC = 4'd6,
    OP_CIR_R   = 4'd7,
    OP_CIR_L   = 4'd8,
    OP_INC_AC  = 4'd9,
    OP_ADD     = 4'd10,
    OP_LOAD    = 4'd11,
    OP_STORE   = 4'd12,
    OP_BRANCH  = 4'd13,
    OP_ISZ     = 4'd14
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] ar_q, ar_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [DWIDTH-1:0] dr_q, dr_d;
  logic [DWIDTH-1:0] ac_q, ac_d;
  logic              e_q, e_d;

  logic [11:0] strobes;
  logic        strobe_onehot;

  assign strobes = {i_add, i_load, i_store, i_branch, i_isz, i_clr_ac,
                    i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac};
  // Exactly one op strobe must be set for i_execute to do anything.
  assign strobe_onehot = (strobes != 12'd0) && ((strobes & (strobes - 12'd1)) == 12'd0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    ar_d    = ar_q;
    ir_d    = ir_q;
    dr_d    = dr_q;
    ac_d    = ac_q;
    e_d     = e_q;

    case (state_q)
      S_IDLE: begin
        if (i_clr_reg) begin
          op_d    = OP_CLR_REG;
          state_d = S_EXEC;
        end else if (i_fetch) begin
          state_d = S_FETCH;
        end else if (i_is_ind) begin
          state_d = S_IND;
        end else if (i_is_dir) begin
          op_d    = OP_DIR;
          state_d = S_EXEC;
        end else if (i_execute) begin
          state_d = S_EXEC;
          op_d    = OP_NONE;
          if (strobe_onehot) begin
            if (i_add) begin
              op_d    = OP_ADD;
              state_d = S_MEM_RD;
            end else if (i_load) begin
              op_d    = OP_LOAD;
              state_d = S_MEM_RD;
            end else if (i_isz) begin
              op_d    = OP_ISZ;
              state_d = S_MEM_RD;
            end else if (i_store) begin
              op_d    = OP_STORE;
              state_d = S_MEM_WR;
            end else if (i_branch) begin
              op_d = OP_BRANCH;
            end else if (i_clr_ac) begin
              op_d = OP_CLR_AC;
            end else if (i_clr_e) begin
              op_d = OP_CLR_E;
            end else if (i_comp_ac) begin
              op_d = OP_COMP_AC;
            end else if (i_load_ac) begin
              op_d = OP_LOAD_AC;
            end else if (i_cir_r) begin
              op_d = OP_CIR_R;
            end else if (i_cir_l) begin
              op_d = OP_CIR_L;
            end else begin
              op_d = OP_INC_AC;
            end
          end
        end
      end

      S_FETCH: begin
        if (i_mem_ack) begin
          ir_d    = i_mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DONE;
        end
      end

      S_IND: begin
        if (i_mem_ack) begin
          ar_d    = i_mem_rdata[AWIDTH-1:0];
          state_d = S_DONE;
        end
      end

      S_MEM_RD: begin
        if (i_mem_ack) begin
          dr_d    = i_mem_rdata;
          state_d = S_EXEC;
        end
      end

      S_MEM_WR: begin
        if (i_mem_ack) begin
          // For isz, DR already holds the incremented value being written.
          if (op_q == OP_ISZ && dr_q == '0) begin
            pc_d = pc_q + 1'b1;
          end
          state_d = S_DONE;
        end
      end

      S_EXEC: begin
        state_d = S_DONE;
        case (op_q)
          OP_CLR_REG: begin
            ac_d = '0;
            e_d  = 1'b0;
            dr_d = '0;
            ar_d = '0;
            ir_d = '0;
          end
          OP_DIR:     ar_d = ir_q[AWIDTH-1:0];
          OP_CLR_AC:  ac_d = '0;
          OP_CLR_E:   e_d  = 1'b0;
          OP_COMP_AC: ac_d = ~ac_q;
          OP_LOAD_AC: ac_d = {{(DWIDTH-8){1'b0}}, ir_q[7:0]};
          OP_CIR_R: begin
            ac_d = {e_q, ac_q[DWIDTH-1:1]};
            e_d  = ac_q[0];
          end
          OP_CIR_L: begin
            ac_d = {ac_q[DWIDTH-2:0], e_q};
            e_d  = ac_q[DWIDTH-1];
          end
          OP_INC_AC:  ac_d = ac_q + 1'b1;
          OP_ADD:     {e_d, ac_d} = {1'b0, ac_q} + {1'b0, dr_q};
          OP_LOAD:    ac_d = dr_q;
          OP_BRANCH:  pc_d = ar_q;
          OP_ISZ: begin
            dr_d    = dr_q + 1'b1;
            state_d = S_MEM_WR;
          end
          default: ;
        endcase
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      pc_q    <= RESET_PC;
      ar_q    <= '0;
      ir_q    <= '0;
      dr_q    <= '0;
      ac_q    <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      dr_q    <= dr_d;
      ac_q    <= ac_d;
      e_q     <= e_d;
    end
  end

  // Address and write data come straight from registers that cannot change
  // while a request is outstanding, so they stay stable until ack.
  always_comb begin
    o_mem_req = (state_q == S_FETCH) || (state_q == S_IND) ||
                (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    o_mem_we  = (state_q == S_MEM_WR);
    case (state_q)
      S_FETCH: o_mem_addr = pc_q;
      S_IND:   o_mem_addr = ir_q[AWIDTH-1:0];
      default: o_mem_addr = ar_q;
    endcase
    o_mem_wdata = (op_q == OP_STORE) ? ac_q : dr_q;
  end

  assign o_ex_done = (state_q == S_DONE);
  assign o_busy    = (state_q != S_IDLE);
  assign o_ir      = ir_q;
  assign o_ac      = ac_q;
  assign o_e       = e_q;
  assign o_pc      = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_exec.sv
`default_nettype none
// =============================================================================
// tb_datapath_exec : directed scoreboard bench for datapath_exec
// Rev 1.0
// =============================================================================
module tb_datapath_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_fetch, i_is_ind, i_is_dir, i_execute;
  logic        i_add, i_load, i_store, i_branch, i_isz;
  logic        i_clr_ac, i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac;
  logic        i_clr_reg;
  logic [15:0] o_ir;
  logic        o_ex_done, o_busy, o_mem_req, o_mem_we;
  logic [11:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        i_mem_ack;
  logic [15:0] o_ac;
  logic        o_e;
  logic [11:0] o_pc;

  logic        resp_ack = 1'b0, force_ack = 1'b0;
  logic [15:0] resp_rdata = '0, force_rdata = '0;
  assign i_mem_ack   = resp_ack | force_ack;
  assign i_mem_rdata = force_ack ? force_rdata : resp_rdata;

  always #5 clk = ~clk;

  datapath_exec #(.DWIDTH(16), .AWIDTH(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset),
    .i_fetch(i_fetch), .i_is_ind(i_is_ind), .i_is_dir(i_is_dir), .i_execute(i_execute),
    .i_add(i_add), .i_load(i_load), .i_store(i_store), .i_branch(i_branch), .i_isz(i_isz),
    .i_clr_ac(i_clr_ac), .i_clr_e(i_clr_e), .i_comp_ac(i_comp_ac), .i_load_ac(i_load_ac),
    .i_cir_r(i_cir_r), .i_cir_l(i_cir_l), .i_inc_ac(i_inc_ac), .i_clr_reg(i_clr_reg),
    .o_ir(o_ir), .o_ex_done(o_ex_done), .o_busy(o_busy),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_ac(o_ac), .o_e(o_e), .o_pc(o_pc)
  );

  localparam logic [16:0] C_CLR_REG = 17'h10000, C_FETCH = 17'h08000, C_IND = 17'h04000,
                          C_DIR = 17'h02000, C_EX = 17'h01000, C_ADD = 17'h00800,
                          C_LOAD = 17'h00400, C_STORE = 17'h00200, C_BRANCH = 17'h00100,
                          C_ISZ = 17'h00080, C_CLR_AC = 17'h00040, C_CLR_E = 17'h00020,
                          C_COMP = 17'h00010, C_LOAD_AC = 17'h00008, C_CIR_R = 17'h00004,
                          C_CIR_L = 17'h00002, C_INC = 17'h00001;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] ac;
    logic        e;
    logic [11:0] pc;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } acc_t;

  exp_t        exp_q[$];
  acc_t        acc_q[$];
  exp_t        mon_x;
  acc_t        resp_a;
  logic [11:0] resp_addr;
  logic        resp_we;
  logic [15:0] resp_wdata;
  logic [15:0] mem [0:4095];
  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  bit          mem_mute = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_regs(input logic [15:0] ir, input logic [15:0] ac,
                             input logic e, input logic [11:0] pc);
    exp_t x;
    x.ir = ir; x.ac = ac; x.e = e; x.pc = pc;
    exp_q.push_back(x);
  endtask

  task automatic expect_acc(input logic we, input logic [11:0] addr, input logic [15:0] wdata);
    acc_t a;
    a.we = we; a.addr = addr; a.wdata = wdata;
    acc_q.push_back(a);
  endtask

  task automatic set_cmd(input logic [16:0] cmd);
    {i_clr_reg, i_fetch, i_is_ind, i_is_dir, i_execute, i_add, i_load, i_store, i_branch,
     i_isz, i_clr_ac, i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac} = cmd;
  endtask

  // Issue one command and wait for its done pulse; exp_n is the number of
  // cycles between the first busy cycle and the done cycle.
  task automatic run(input logic [16:0] cmd, input int exp_n);
    int n;
    @(negedge clk);
    set_cmd(cmd);
    @(negedge clk);
    set_cmd('0);
    n = 0;
    while (o_ex_done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("done_timeout", 32'(n), 32'(exp_n));
    else         chk("latency", 32'(n), 32'(exp_n));
  endtask

  // Scoreboard monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (o_ex_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_x = exp_q.pop_front();
        chk("ir", 32'(o_ir), 32'(mon_x.ir));
        chk("ac", 32'(o_ac), 32'(mon_x.ac));
        chk("e",  32'(o_e),  32'(mon_x.e));
        chk("pc", 32'(o_pc), 32'(mon_x.pc));
      end
    end
  end

  // Memory responder: checks each access against the expected-access queue,
  // holds ack off for mem_lat cycles, then returns data / commits the write.
  always begin
    @(negedge clk);
    if (!mem_mute && o_mem_req === 1'b1 && reset === 1'b0) begin
      if (acc_q.size() == 0) begin
        chk("unexpected_access", 32'd1, 32'd0);
      end else begin
        resp_a = acc_q.pop_front();
        chk("mem_we",   32'(o_mem_we),   32'(resp_a.we));
        chk("mem_addr", 32'(o_mem_addr), 32'(resp_a.addr));
        if (resp_a.we) chk("mem_wdata", 32'(o_mem_wdata), 32'(resp_a.wdata));
      end
      resp_addr  = o_mem_addr;
      resp_we    = o_mem_we;
      resp_wdata = o_mem_wdata;
      repeat (mem_lat) begin
        @(negedge clk);
        chk("req_held",    32'(o_mem_req),  32'd1);
        chk("addr_stable", 32'(o_mem_addr), 32'(resp_addr));
      end
      resp_rdata = mem[resp_addr];
      if (resp_we) mem[resp_addr] = resp_wdata;
      resp_ack = 1'b1;
      @(negedge clk);
      resp_ack = 1'b0;
    end
  end

  initial begin
    reset = 1'b1;
    set_cmd('0);
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h000] = 16'h2005;
    mem[12'h001] = 16'h715A;
    mem[12'h002] = 16'h1005;
    mem[12'h003] = 16'h0020;
    mem[12'h005] = 16'hFFFF;
    mem[12'h010] = 16'hFFFF;
    mem[12'h020] = 16'h0010;
    mem[12'h022] = 16'h0FFF;
    mem[12'hFFF] = 16'h8010;
    mem[12'hABC] = 16'h1234;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ir",   32'(o_ir),      32'h0);
    chk("rst_ac",   32'(o_ac),      32'h0);
    chk("rst_e",    32'(o_e),       32'h0);
    chk("rst_pc",   32'(o_pc),      32'h000);
    chk("rst_busy", 32'(o_busy),    32'h0);
    chk("rst_req",  32'(o_mem_req), 32'h0);
    chk("rst_done", 32'(o_ex_done), 32'h0);

    // Fetch with ack three cycles after request.
    mem_lat = 3;
    expect_acc(1'b0, 12'h000, '0); expect_regs(16'h2005, 16'h0000, 1'b0, 12'h001);
    run(C_FETCH, 4);
    mem_lat = 1;
    expect_acc(1'b0, 12'h001, '0); expect_regs(16'h715A, 16'h0000, 1'b0, 12'h002);
    run(C_FETCH, 2);

    // Register ops: build E=1 via complement + rotate right, then load_ac / cir_l.
    expect_regs(16'h715A, 16'hFFFF, 1'b0, 12'h002); run(C_EX | C_COMP, 1);
    expect_regs(16'h715A, 16'h7FFF, 1'b1, 12'h002); run(C_EX | C_CIR_R, 1);
    expect_regs(16'h715A, 16'h005A, 1'b1, 12'h002); run(C_EX | C_LOAD_AC, 1);
    expect_regs(16'h715A, 16'h00B5, 1'b0, 12'h002); run(C_EX | C_CIR_L, 1);
    expect_regs(16'h715A, 16'h0000, 1'b0, 12'h002); run(C_EX | C_CLR_AC, 1);
    expect_regs(16'h715A, 16'h0001, 1'b0, 12'h002); run(C_EX | C_INC, 1);
    expect_regs(16'h715A, 16'h0002, 1'b0, 12'h002); run(C_EX | C_INC, 1);

    // add: AC=0002 + mem[005]=FFFF -> carry out.
    expect_acc(1'b0, 12'h002, '0); expect_regs(16'h1005, 16'h0002, 1'b0, 12'h003);
    run(C_FETCH, 2);
    expect_regs(16'h1005, 16'h0002, 1'b0, 12'h003); run(C_DIR, 1);
    expect_acc(1'b0, 12'h005, '0); expect_regs(16'h1005, 16'h0001, 1'b1, 12'h003);
    run(C_EX | C_ADD, 3);

    // Branch to 020, fetch there, then isz on mem[010].
    expect_acc(1'b0, 12'h003, '0); expect_regs(16'h0020, 16'h0001, 1'b1, 12'h004);
    run(C_FETCH, 2);
    expect_regs(16'h0020, 16'h0001, 1'b1, 12'h004); run(C_DIR, 1);
    expect_regs(16'h0020, 16'h0001, 1'b1, 12'h020); run(C_EX | C_BRANCH, 1);
    expect_acc(1'b0, 12'h020, '0); expect_regs(16'h0010, 16'h0001, 1'b1, 12'h021);
    run(C_FETCH, 2);
    expect_regs(16'h0010, 16'h0001, 1'b1, 12'h021); run(C_DIR, 1);
    expect_acc(1'b0, 12'h010, '0); expect_acc(1'b1, 12'h010, 16'h0000);
    expect_regs(16'h0010, 16'h0001, 1'b1, 12'h022);
    run(C_EX | C_ISZ, 5);
    chk("isz_mem_wrap", 32'(mem[12'h010]), 32'h0000);
    mem[12'h010] = 16'h0003;
    expect_acc(1'b0, 12'h010, '0); expect_acc(1'b1, 12'h010, 16'h0004);
    expect_regs(16'h0010, 16'h0001, 1'b1, 12'h022);
    run(C_EX | C_ISZ, 5);
    chk("isz_mem_inc", 32'(mem[12'h010]), 32'h0004);

    // PC wrap FFF -> 000 on fetch.
    expect_acc(1'b0, 12'h022, '0); expect_regs(16'h0FFF, 16'h0001, 1'b1, 12'h023);
    run(C_FETCH, 2);
    expect_regs(16'h0FFF, 16'h0001, 1'b1, 12'h023); run(C_DIR, 1);
    expect_regs(16'h0FFF, 16'h0001, 1'b1, 12'hFFF); run(C_EX | C_BRANCH, 1);
    expect_acc(1'b0, 12'hFFF, '0); expect_regs(16'h8010, 16'h0001, 1'b1, 12'h000);
    run(C_FETCH, 2);

    // Indirect resolve to ABC, load then store there.
    mem[12'h010] = 16'h0ABC;
    expect_acc(1'b0, 12'h010, '0); expect_regs(16'h8010, 16'h0001, 1'b1, 12'h000);
    run(C_IND, 2);
    expect_acc(1'b0, 12'hABC, '0); expect_regs(16'h8010, 16'h1234, 1'b1, 12'h000);
    run(C_EX | C_LOAD, 3);
    mem[12'hABC] = 16'h0000;
    expect_acc(1'b1, 12'hABC, 16'h1234); expect_regs(16'h8010, 16'h1234, 1'b1, 12'h000);
    run(C_EX | C_STORE, 2);
    chk("store_mem", 32'(mem[12'hABC]), 32'h1234);

    // Illegal strobe combinations still complete without side effects.
    expect_regs(16'h8010, 16'h1234, 1'b1, 12'h000); run(C_EX | C_CLR_AC | C_INC, 1);
    expect_regs(16'h8010, 16'h1234, 1'b1, 12'h000); run(C_EX, 1);
    expect_regs(16'h8010, 16'h1234, 1'b0, 12'h000); run(C_EX | C_CLR_E, 1);

    // Priority: is_dir beats execute; clr_reg beats fetch.
    expect_regs(16'h8010, 16'h1234, 1'b0, 12'h000); run(C_DIR | C_EX | C_CLR_AC, 1);
    expect_regs(16'h8010, 16'h1234, 1'b0, 12'h010); run(C_EX | C_BRANCH, 1);
    expect_regs(16'h0000, 16'h0000, 1'b0, 12'h010); run(C_CLR_REG | C_FETCH, 1);
    expect_regs(16'h0000, 16'h0000, 1'b0, 12'h000); run(C_EX | C_BRANCH, 1);

    // Reset while a fetch waits for ack; the late ack must be ignored.
    expect_acc(1'b0, 12'h000, '0); expect_regs(16'h2005, 16'h0000, 1'b0, 12'h001);
    run(C_FETCH, 2);
    mem_mute = 1'b1;
    @(negedge clk);
    set_cmd(C_FETCH);
    @(negedge clk);
    set_cmd('0);
    chk("abort_req_up",  32'(o_mem_req),  32'd1);
    chk("abort_addr",    32'(o_mem_addr), 32'h001);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_drop", 32'(o_mem_req), 32'd0);
    chk("abort_pc",       32'(o_pc),      32'h000);
    chk("abort_busy",     32'(o_busy),    32'd0);
    force_rdata = 16'hBEEF;
    force_ack   = 1'b1;
    @(negedge clk);
    force_ack   = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_ack_ir", 32'(o_ir), 32'h0000);
    chk("late_ack_pc", 32'(o_pc), 32'h000);
    mem_mute = 1'b0;

    repeat (3) @(negedge clk);
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
